// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter feeding a single UART-style serializer: one requester's
// byte per frame, framed START / 8 data LSB-first / even parity / STOP.
module serial_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              tx_out,
  output logic              busy,
  output logic [1:0]        cur_id,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  localparam logic [7:0] TMAX = 8'(BAUD_DIV - 1);

  state_e          state_q, state_d;
  logic [7:0]      timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      last_q, last_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [1:0]      cur_id_q, cur_id_d;
  logic            frame_done_q, frame_done_d;

  logic            grant_vld;
  logic [1:0]      grant_id;
  logic            bit_end;
  logic [2:0]      nxt_idx;

  // Scan from lowest to highest priority so the nearest requester after
  // last_q is the final assignment; offset NREQ wraps to last_q itself.
  always_comb begin
    logic [1:0] idx;
    grant_vld = 1'b0;
    grant_id  = last_q;
    idx       = last_q;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (req[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign bit_end = (timer_q == TMAX);
  assign nxt_idx = bit_idx_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    data_d       = data_q;
    last_d       = last_q;
    ack_d        = '0;
    tx_d         = tx_q;
    busy_d       = busy_q;
    cur_id_d     = cur_id_q;
    frame_done_d = 1'b0;

    if (state_q != S_IDLE)
      timer_d = bit_end ? 8'd0 : timer_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (en && grant_vld) begin
          state_d         = S_START;
          timer_d         = 8'd0;
          bit_idx_d       = 3'd0;
          data_d          = req_data[8*grant_id +: 8];
          last_d          = grant_id;
          ack_d[grant_id] = 1'b1;
          cur_id_d        = grant_id;
          tx_d            = 1'b0;
          busy_d          = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = data_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = S_PARITY;
            tx_d    = ^data_q;
          end else begin
            bit_idx_d = nxt_idx;
            tx_d      = data_q[nxt_idx];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d      = S_IDLE;
          tx_d         = 1'b1;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= 8'd0;
      bit_idx_q    <= 3'd0;
      data_q       <= 8'd0;
      last_q       <= 2'd3;
      ack_q        <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      cur_id_q     <= 2'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      data_q       <= data_d;
      last_q       <= last_d;
      ack_q        <= ack_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      cur_id_q     <= cur_id_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ack        = ack_q;
  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign cur_id     = cur_id_q;
  assign frame_done = frame_done_q;

endmodule
